uart_cmd_controller: RTL and testbench

Frame parser and command sequencer between the Arduino UART byte receiver and the command consumers in the fabric. It pulls bytes from the receiver over a valid/ready handshake and assembles GUI frames (sync, opcode, length, payload, optional checksum). Each complete frame is presented as a single command on a second valid/ready handshake. Malformed or stalled frames are dropped and counted.

---
 rtl/uart_cmd_controller_if.sv | 26 ++
 rtl/uart_cmd_controller.sv | 169 ++++++++++++++++
 tb/tb_uart_cmd_controller.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_controller_if.sv
// Byte-stream and command handshake bundle for uart_cmd_controller.
// master: UART receiver side driving bytes and command consumer side.
// slave:  the frame parser itself.
interface uart_cmd_controller_if #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned MAX_PAYLOAD = 4
);
    logic [DATA_BITS-1:0]     rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [7:0]               cmd_opcode;
    logic [2:0]               cmd_len;
    logic [8*MAX_PAYLOAD-1:0] cmd_payload;
    logic                     cmd_valid;
    logic                     cmd_ready;

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  rx_ready, cmd_opcode, cmd_len, cmd_payload, cmd_valid
    );

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output rx_ready, cmd_opcode, cmd_len, cmd_payload, cmd_valid
    );
endinterface

// File: rtl/uart_cmd_controller.sv
// UART GUI frame parser: SYNC, OPCODE, LEN, PAYLOAD[LEN], optional XOR checksum.
// Each complete frame is issued as one command; malformed or stalled frames
// are dropped with a one-cycle frame_err pulse and a saturating err_count.
// Optional feature macro: CMD_CHECKSUM_EN (adds trailing checksum byte and CHECK state).
module uart_cmd_controller #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned MAX_PAYLOAD  = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 50_000
) (
    input  logic                   clk_50,
    input  logic                   reset,
    uart_cmd_controller_if.slave   bus,
    output logic                   frame_err,
    output logic [7:0]             err_count
);

    localparam int unsigned TMO_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]  MAX_LEN  = 8'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        HUNT,
        OPCODE,
        LEN,
        PAYLOAD,
`ifdef CMD_CHECKSUM_EN
        CHECK,
`endif
        ISSUE
    } state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       pay_idx;
    logic [DATA_BITS-1:0] rx_word;
    logic [7:0]       rx_byte;
    logic             accept;
    logic             err_c;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]       chk;
`endif

    assign rx_word = bus.rx_data;
    assign rx_byte = rx_word[7:0];
    assign accept  = bus.rx_valid && bus.rx_ready;

    // Frame drop conditions: oversize length, bad checksum, inter-byte timeout.
    always_comb begin
        err_c = 1'b0;
        if (state != HUNT && state != ISSUE) begin
            if (accept) begin
                if (state == LEN && rx_byte > MAX_LEN) err_c = 1'b1;
`ifdef CMD_CHECKSUM_EN
                if (state == CHECK && rx_byte != chk) err_c = 1'b1;
`endif
            end else if (tmo_cnt == TMO_LAST) begin
                err_c = 1'b1;
            end
        end
    end

    // Frame FSM, timeout counter, command registers and error accounting.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state           <= HUNT;
            bus.rx_ready    <= 1'b1;
            bus.cmd_valid   <= 1'b0;
            bus.cmd_opcode  <= 8'd0;
            bus.cmd_len     <= 3'd0;
            bus.cmd_payload <= '0;
            frame_err       <= 1'b0;
            err_count       <= 8'd0;
            tmo_cnt         <= '0;
            pay_idx         <= 3'd0;
`ifdef CMD_CHECKSUM_EN
            chk             <= 8'd0;
`endif
        end else begin
            frame_err <= err_c;
            if (err_c && err_count != 8'hFF) err_count <= err_count + 8'd1;

            case (state)
                HUNT: begin
                    if (accept && rx_byte == SYNC_BYTE) begin
                        state   <= OPCODE;
                        tmo_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        bus.rx_ready  <= 1'b1;
                        state         <= HUNT;
                    end
                end
                default: begin
                    if (accept) begin
                        tmo_cnt <= '0;
                        case (state)
                            OPCODE: begin
                                bus.cmd_opcode <= rx_byte;
`ifdef CMD_CHECKSUM_EN
                                chk <= rx_byte;
`endif
                                state <= LEN;
                            end
                            LEN: begin
                                if (rx_byte > MAX_LEN) begin
                                    state <= HUNT;
                                end else begin
                                    bus.cmd_len     <= 3'(rx_byte);
                                    bus.cmd_payload <= '0;
                                    pay_idx         <= 3'd0;
`ifdef CMD_CHECKSUM_EN
                                    chk <= chk ^ rx_byte;
                                    state <= (rx_byte == 8'd0) ? CHECK : PAYLOAD;
`else
                                    if (rx_byte == 8'd0) begin
                                        state         <= ISSUE;
                                        bus.cmd_valid <= 1'b1;
                                        bus.rx_ready  <= 1'b0;
                                    end else begin
                                        state <= PAYLOAD;
                                    end
`endif
                                end
                            end
                            PAYLOAD: begin
                                for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                                    if (pay_idx == 3'(i)) bus.cmd_payload[8*i +: 8] <= rx_byte;
                                end
                                pay_idx <= pay_idx + 3'd1;
`ifdef CMD_CHECKSUM_EN
                                chk <= chk ^ rx_byte;
                                if (pay_idx + 3'd1 == bus.cmd_len) state <= CHECK;
`else
                                if (pay_idx + 3'd1 == bus.cmd_len) begin
                                    state         <= ISSUE;
                                    bus.cmd_valid <= 1'b1;
                                    bus.rx_ready  <= 1'b0;
                                end
`endif
                            end
`ifdef CMD_CHECKSUM_EN
                            CHECK: begin
                                if (rx_byte == chk) begin
                                    state         <= ISSUE;
                                    bus.cmd_valid <= 1'b1;
                                    bus.rx_ready  <= 1'b0;
                                end else begin
                                    state <= HUNT;
                                end
                            end
`endif
                            default: state <= HUNT;
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= HUNT;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Scoreboard bench for uart_cmd_controller: stimulus pushes expected commands,
// a negedge monitor pops and compares on every cmd_valid && cmd_ready.
module tb_uart_cmd_controller;

    localparam int unsigned MAXP = 4;
    localparam int unsigned TMO  = 64;

    logic       clk_50 = 1'b0;
    logic       reset  = 1'b0;
    logic       frame_err;
    logic [7:0] err_count;

    uart_cmd_controller_if #(.DATA_BITS(8), .MAX_PAYLOAD(MAXP)) bus ();

    uart_cmd_controller #(
        .DATA_BITS(8), .MAX_PAYLOAD(MAXP), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk_50(clk_50), .reset(reset), .bus(bus.slave),
        .frame_err(frame_err), .err_count(err_count)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  len;
        logic [31:0] pay;
    } cmd_t;

    cmd_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         err_pulses = 0;
    int         exp_pulses = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: command pops, hold stability, single-cycle valid, error pulse count.
    logic hs_prev   = 1'b0;
    logic hold_prev = 1'b0;
    cmd_t held;
    always @(negedge clk_50) begin
        if (!reset) begin
            hs_prev   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (frame_err) err_pulses++;
            if (hs_prev) check("cmd_valid_drop", 32'(bus.cmd_valid), 32'd0);
            if (bus.cmd_valid && hold_prev) begin
                check("hold_opcode",  32'(bus.cmd_opcode), 32'(held.op));
                check("hold_len",     32'(bus.cmd_len),    32'(held.len));
                check("hold_payload", bus.cmd_payload,     held.pay);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_cmd: got opcode %0h with no command expected", bus.cmd_opcode);
                end else begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    check("cmd_opcode",  32'(bus.cmd_opcode), 32'(e.op));
                    check("cmd_len",     32'(bus.cmd_len),    32'(e.len));
                    check("cmd_payload", bus.cmd_payload,     e.pay);
                end
            end
            hs_prev   = bus.cmd_valid && bus.cmd_ready;
            hold_prev = bus.cmd_valid && !bus.cmd_ready;
            held.op   = bus.cmd_opcode;
            held.len  = bus.cmd_len;
            held.pay  = bus.cmd_payload;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        forever begin
            @(negedge clk_50);
            if (bus.rx_ready) break;
            n++;
            if (n > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_ready_timeout: byte %0h never accepted", b);
                break;
            end
        end
        @(posedge clk_50);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] len,
                              input logic [31:0] pay, input logic bad);
        logic [7:0] x;
        send_byte(8'hA5);
        send_byte(op);
        send_byte(len);
        x = op ^ len;
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pay[8*i +: 8]);
            x = x ^ pay[8*i +: 8];
        end
`ifdef CMD_CHECKSUM_EN
        send_byte(bad ? (x ^ 8'h01) : x);
`else
        if (bad) x = 8'h00;
`endif
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [2:0] len, input logic [31:0] pay);
        cmd_t c;
        c.op  = op;
        c.len = len;
        c.pay = pay;
        exp_q.push_back(c);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk_50);
            n++;
        end
        repeat (3) @(posedge clk_50);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_err();
        exp_pulses++;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic check_errs(input string name);
        repeat (2) @(posedge clk_50);
        #1;
        check({name, "_err_count"}, 32'(err_count), 32'(exp_cnt));
        check({name, "_err_pulses"}, 32'(err_pulses), 32'(exp_pulses));
    endtask

    task automatic check_reset_vals(input string name);
        @(negedge clk_50);
        check({name, "_rx_ready"},    32'(bus.rx_ready),    32'd1);
        check({name, "_cmd_valid"},   32'(bus.cmd_valid),   32'd0);
        check({name, "_cmd_opcode"},  32'(bus.cmd_opcode),  32'd0);
        check({name, "_cmd_len"},     32'(bus.cmd_len),     32'd0);
        check({name, "_cmd_payload"}, bus.cmd_payload,      32'd0);
        check({name, "_frame_err"},   32'(frame_err),       32'd0);
        check({name, "_err_count"},   32'(err_count),       32'd0);
    endtask

    initial begin
        bus.rx_data   = 8'd0;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b1;
        repeat (2) @(posedge clk_50);
        check_reset_vals("reset");
        @(posedge clk_50);
        #1;
        reset = 1'b1;

        // Basic frame A5 10 02 11 22 (+21 checksum when enabled).
        push_cmd(8'h10, 3'd2, 32'h0000_2211);
        send_frame(8'h10, 8'd2, 32'h0000_2211, 1'b0);
        drain("basic_drain");
        check_errs("basic");

`ifdef CMD_CHECKSUM_EN
        // Same frame with checksum 20 instead of 21 is dropped.
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h20);
        expect_err();
        check_errs("bad_chk");
`endif

        // Junk byte, then oversize LEN; then a zero-length frame.
        send_byte(8'h33); send_byte(8'hA5); send_byte(8'h07); send_byte(8'h05);
        expect_err();
        check_errs("len_too_big");
        push_cmd(8'h01, 3'd0, 32'h0);
        send_frame(8'h01, 8'd0, 32'h0, 1'b0);
        drain("zero_len_drain");

        // Maximum payload, byte 0 in the low lane.
        push_cmd(8'hC3, 3'd4, 32'hDEAD_BEEF);
        send_frame(8'hC3, 8'd4, 32'hDEAD_BEEF, 1'b0);
        drain("max_len_drain");

        // Byte arriving on the last counter value is accepted without error.
        send_byte(8'hA5); send_byte(8'h42);
        repeat (TMO - 1) @(posedge clk_50);
        #1;
        send_byte(8'h01);
        send_byte(8'h5A);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h42 ^ 8'h01 ^ 8'h5A);
`endif
        push_cmd(8'h42, 3'd1, 32'h0000_005A);
        drain("tmo_edge_drain");
        check_errs("tmo_edge");

        // Full timeout after A5 42.
        send_byte(8'hA5); send_byte(8'h42);
        repeat (TMO) @(posedge clk_50);
        #1;
        @(negedge clk_50);
        check("timeout_frame_err", 32'(frame_err), 32'd1);
        expect_err();
        @(posedge clk_50);
        #1;
        check_errs("timeout");

        // Backpressure: consumer stalls 10 cycles, next frame byte must be held.
        bus.cmd_ready = 1'b0;
        push_cmd(8'h55, 3'd3, 32'h0033_2211);
        send_frame(8'h55, 8'd3, 32'h0033_2211, 1'b0);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk_50);
                    check("hold_rx_ready",  32'(bus.rx_ready),  32'd0);
                    check("hold_cmd_valid", 32'(bus.cmd_valid), 32'd1);
                end
                @(posedge clk_50);
                #1;
                bus.cmd_ready = 1'b1;
            end
            begin
                push_cmd(8'h66, 3'd1, 32'h0000_0077);
                send_frame(8'h66, 8'd1, 32'h0000_0077, 1'b0);
            end
        join
        drain("hold_drain");
        check_errs("hold");

        // Saturation of err_count.
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07);
            expect_err();
        end
        check_errs("saturate");
        check("saturate_255", 32'(err_count), 32'd255);

        // Reset mid-frame, then a clean frame.
        send_byte(8'hA5); send_byte(8'h10);
        reset = 1'b0;
        exp_cnt = 8'd0;
        check_reset_vals("mid_reset");
        @(posedge clk_50);
        #1;
        reset = 1'b1;
        push_cmd(8'h99, 3'd2, 32'h0000_BBAA);
        send_frame(8'h99, 8'd2, 32'h0000_BBAA, 1'b0);
        drain("post_reset_drain");
        check_errs("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
